// File: rtl/mandelbrot_iter_ctrl_if.sv
// Point-in / result-out handshake bundle for the Mandelbrot iteration sequencer.
// master = pixel source / colour stage side, slave = the sequencer.
interface mandelbrot_iter_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int CTR_WIDTH = 6
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [WIDTH-1:0]     in_cr;
  logic signed [WIDTH-1:0]     in_ci;
  logic        [CTR_WIDTH-1:0] max_iter;
  logic                        out_valid;
  logic                        out_ready;
  logic        [CTR_WIDTH-1:0] iter_count;
  logic                        escaped;

  modport master (
    output in_valid, in_cr, in_ci, max_iter, out_ready,
    input  in_ready, out_valid, iter_count, escaped
  );

  modport slave (
    input  in_valid, in_cr, in_ci, max_iter, out_ready,
    output in_ready, out_valid, iter_count, escaped
  );
endinterface

// File: rtl/mandelbrot_iter_ctrl.sv
// Runs one Mandelbrot pixel to completion around an external combinational ALU.
// Optional MANDELBROT_ABORT_EN adds an abort input that drops RUN/DONE back to IDLE.
module mandelbrot_iter_ctrl #(
  parameter int WIDTH     = 8,
  parameter int CTR_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef MANDELBROT_ABORT_EN
  input  logic                    abort,
`endif
  mandelbrot_iter_ctrl_if.slave   pix,
  output logic signed [WIDTH-1:0] alu_cr,
  output logic signed [WIDTH-1:0] alu_ci,
  output logic signed [WIDTH-1:0] alu_zr,
  output logic signed [WIDTH-1:0] alu_zi,
  input  logic signed [WIDTH-1:0] alu_out_zr,
  input  logic signed [WIDTH-1:0] alu_out_zi,
  input  logic                    alu_size,
  input  logic                    alu_overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic signed [WIDTH-1:0] cr, ci, zr, zi;
  logic [CTR_WIDTH-1:0]    iter, max_lat;
  logic                    esc;
  logic                    accept, step, set_esc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Limit check outranks escape so a point that escapes exactly on the
  // last allowed iteration still reports as limit-stopped.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    set_esc   = 1'b0;
    case (state)
      IDLE: if (pix.in_valid) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (iter == max_lat) begin
          state_nxt = DONE;
        end else if (alu_size | alu_overflow) begin
          state_nxt = DONE;
          set_esc   = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      DONE: if (pix.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef MANDELBROT_ABORT_EN
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      step      = 1'b0;
      set_esc   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr      <= '0;
      ci      <= '0;
      zr      <= '0;
      zi      <= '0;
      iter    <= '0;
      max_lat <= '0;
      esc     <= 1'b0;
    end else if (accept) begin
      cr      <= pix.in_cr;
      ci      <= pix.in_ci;
      max_lat <= pix.max_iter;
      zr      <= '0;
      zi      <= '0;
      iter    <= '0;
      esc     <= 1'b0;
    end else if (step) begin
      zr   <= alu_out_zr;
      zi   <= alu_out_zi;
      iter <= iter + CTR_WIDTH'(1);
    end else if (set_esc) begin
      esc <= 1'b1;
    end
  end

  assign pix.in_ready   = (state == IDLE);
  assign pix.out_valid  = (state == DONE);
  assign pix.iter_count = iter;
  assign pix.escaped    = esc;

  assign alu_cr = cr;
  assign alu_ci = ci;
  assign alu_zr = zr;
  assign alu_zi = zi;

endmodule
